corefifo_sync_reset_seq: RTL

Reset/flush sequencer for the FIFO's pointer synchronizer chains and flag logic in one clock domain. It drives the active-low synchronous clear (srstn) of the N-stage synchronizers. After the clear, it waits until the chains hold valid data, then opens the write/read enable gates. It also services runtime flush requests from control logic with a req/ack handshake, so flags never see stale partially-synchronized pointers.

---
 rtl/corefifo_seq_pkg.sv | 13 +
 rtl/corefifo_sync_reset_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/corefifo_seq_pkg.sv
// State encoding shared by the FIFO reset/flush sequencer.
package corefifo_seq_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    FLUSH  = 2'd0,
    SETTLE = 2'd1,
    READY  = 2'd2,
    DRAIN  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/corefifo_sync_reset_seq.sv
// Reset/flush sequencer for FIFO pointer synchronizers and flag logic.
// Optional write-drain phase before a requested flush: define COREFIFO_SEQ_DRAIN_EN.
module corefifo_sync_reset_seq
  import corefifo_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES    = 2,
  parameter int unsigned FLUSH_CYCLES  = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned DRAIN_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             flush_req,
  input  logic             wr_active,
  output logic             srstn,
  output logic             fifo_ready,
  output logic             wr_gate,
  output logic             rd_gate,
  output logic             flush_ack,
  output logic [CNT_W-1:0] flush_count
`ifdef COREFIFO_SEQ_DRAIN_EN
  ,
  output logic             drain_timeout
`endif
);

  localparam logic [CNT_W-1:0] FLUSH_LAST  = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(NUM_STAGES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  seq_state_t       r_state;
  seq_state_t       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             r_pend;
  logic             w_set_pend;
  logic             r_srstn;
  logic             r_ready;
  logic             r_ack;
  logic [CNT_W-1:0] r_flush_count;
  logic             w_srstn;
  logic             w_ready;
  logic             w_ack;
  logic [CNT_W-1:0] w_flush_count;

`ifdef COREFIFO_SEQ_DRAIN_EN
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  logic r_tmo;
  logic w_tmo;
`else
  logic w_unused_wr_active;
  assign w_unused_wr_active = wr_active;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state       <= FLUSH;
      r_cnt         <= '0;
      r_pend        <= 1'b0;
      r_srstn       <= 1'b0;
      r_ready       <= 1'b0;
      r_ack         <= 1'b0;
      r_flush_count <= '0;
`ifdef COREFIFO_SEQ_DRAIN_EN
      r_tmo         <= 1'b0;
`endif
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_next_cnt;
      r_pend        <= w_set_pend | (r_pend & ~w_ack);
      r_srstn       <= w_srstn;
      r_ready       <= w_ready;
      r_ack         <= w_ack;
      r_flush_count <= w_flush_count;
`ifdef COREFIFO_SEQ_DRAIN_EN
      r_tmo         <= r_tmo | w_tmo;
`endif
    end
  end

  // The ack cycle blocks a new request so every requested flush is acknowledged once.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_set_pend   = 1'b0;
`ifdef COREFIFO_SEQ_DRAIN_EN
    w_tmo        = 1'b0;
`endif
    case (r_state)
      FLUSH: begin
        if (r_cnt == FLUSH_LAST) begin
          w_next_state = SETTLE;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + CNT_ONE;
        end
      end
      SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_next_state = READY;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + CNT_ONE;
        end
      end
      READY: begin
        if (flush_req && !r_ack) begin
`ifdef COREFIFO_SEQ_DRAIN_EN
          w_next_state = DRAIN;
`else
          w_next_state = FLUSH;
`endif
          w_next_cnt   = '0;
          w_set_pend   = 1'b1;
        end
      end
`ifdef COREFIFO_SEQ_DRAIN_EN
      DRAIN: begin
        if (!wr_active) begin
          w_next_state = FLUSH;
          w_next_cnt   = '0;
        end else if (r_cnt == DRAIN_LAST) begin
          w_next_state = FLUSH;
          w_next_cnt   = '0;
          w_tmo        = 1'b1;
        end else begin
          w_next_cnt = r_cnt + CNT_ONE;
        end
      end
`endif
      default: begin
        w_next_state = FLUSH;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered.
  always_comb begin
    w_srstn       = (w_next_state != FLUSH);
    w_ready       = (w_next_state == READY);
    w_ack         = r_pend && (r_state == SETTLE) && (w_next_state == READY);
    w_flush_count = r_flush_count;
    if (w_ack && (r_flush_count != '1)) begin
      w_flush_count = r_flush_count + CNT_ONE;
    end
  end

  assign srstn       = r_srstn;
  assign fifo_ready  = r_ready;
  assign wr_gate     = r_ready;
  assign rd_gate     = r_ready;
  assign flush_ack   = r_ack;
  assign flush_count = r_flush_count;
`ifdef COREFIFO_SEQ_DRAIN_EN
  assign drain_timeout = r_tmo;
`endif

endmodule
